// File: rtl/half_mult_issue_stage.sv
// ---------------------------------------------------------------------------
// half_mult_issue_stage
//
// Issue/capture stage wrapped around the combinational half-precision
// multiplier float_mult_16bit. Operand pairs arrive on a valid/ready stream
// and are buffered in a small in-order FIFO. The FIFO head drives the
// multiplier operand bus. The returned product is registered into a
// valid/ready output slot, together with the operation tag and exception
// flags. Up to DEPTH + 1 operations can be in flight: DEPTH in the FIFO and
// one in the output register.
//
// Ports
//   CLK           clock, all flops on posedge
//   RST           asynchronous reset, active-high
//   in_valid      operand pair offered
//   in_ready      stage can accept a pair (FIFO not full, register based)
//   in_a, in_b    IEEE half operands
//   in_tag        opaque tag returned with the result
//   mult_float1   FIFO head operand a to the multiplier (0 when empty)
//   mult_float2   FIFO head operand b to the multiplier (0 when empty)
//   mult_product  product returned by the multiplier (combinational)
//   out_valid     result register holds a valid result
//   out_ready     consumer accepts the result
//   out_product   registered product
//   out_tag       registered tag
//   out_flags     registered {ovf, inf, snan, qnan, zero}
//   occupancy     FIFO entry count
// ---------------------------------------------------------------------------
module half_mult_issue_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [15:0]              mult_float1,
    output logic [15:0]              mult_float2,
    input  logic [15:0]              mult_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_product,
    output logic [TAG_W-1:0]         out_tag,
    output logic [4:0]               out_flags,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Product pattern the multiplier emits when a normal result overflows.
    localparam logic [15:0] OVF_PATTERN = 16'hFDFF;

    // -----------------------------------------------------------------------
    // Operand classification helpers
    // -----------------------------------------------------------------------
    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic is_qnan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && x[9];
    endfunction

    function automatic logic is_snan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && !x[9] && (x[8:0] != 9'd0);
    endfunction

    // Priority zero > qnan > snan > inf > normal; at most one class bit is
    // set. Only +0 counts as zero; -0 is treated as an ordinary operand.
    function automatic logic [4:0] classify_flags(input logic [15:0] a,
                                                  input logic [15:0] b,
                                                  input logic [15:0] p);
        logic a_zero;
        logic b_zero;
        logic f_zero;
        logic f_qnan;
        logic f_snan;
        logic f_inf;
        logic [4:0] f;
        a_zero = (a == 16'h0000);
        b_zero = (b == 16'h0000);
        f_zero = (a_zero && !is_inf(b)) || (b_zero && !is_inf(a));
        // +0 x inf is an invalid operation and is reported as a quiet NaN.
        f_qnan = is_qnan(a) || is_qnan(b) ||
                 (a_zero && is_inf(b)) || (b_zero && is_inf(a));
        f_snan = is_snan(a) || is_snan(b);
        f_inf  = is_inf(a) || is_inf(b);
        f = 5'b00000;
        if (f_zero) begin
            f[0] = 1'b1;
        end else if (f_qnan) begin
            f[1] = 1'b1;
        end else if (f_snan) begin
            f[2] = 1'b1;
        end else if (f_inf) begin
            f[3] = 1'b1;
        end else if (p == OVF_PATTERN) begin
            f[4] = 1'b1;
        end
        return f;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [15:0]      mem_a_q   [DEPTH];
    logic [15:0]      mem_b_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             out_valid_q,   out_valid_d;
    logic [15:0]      out_product_q, out_product_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;
    logic [4:0]       out_flags_q,   out_flags_d;

    logic fifo_empty;
    logic push;
    logic load;

    // in_ready depends on the registered count only, so out_ready never
    // reaches it combinationally; a full FIFO refuses even while popping.
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign load       = !fifo_empty && (!out_valid_q || out_ready);

    assign mult_float1 = fifo_empty ? 16'h0000 : mem_a_q[rd_ptr_q];
    assign mult_float2 = fifo_empty ? 16'h0000 : mem_b_q[rd_ptr_q];

    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;
    assign out_flags   = out_flags_q;
    assign occupancy   = count_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_tag_d     = out_tag_q;
        out_flags_d   = out_flags_q;

        // DEPTH is a power of two, so natural overflow wraps the pointers.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (load) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (load) begin
            out_valid_d   = 1'b1;
            out_product_d = mult_product;
            out_tag_d     = mem_tag_q[rd_ptr_q];
            out_flags_d   = classify_flags(mult_float1, mult_float2, mult_product);
        end else if (out_ready && out_valid_q) begin
            out_valid_d   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= 16'h0000;
            out_tag_q     <= '0;
            out_flags_q   <= 5'b00000;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
            out_flags_q   <= out_flags_d;
        end
    end

    // FIFO storage needs no reset: an entry is only read after it is written.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a_q[wr_ptr_q]   <= in_a;
            mem_b_q[wr_ptr_q]   <= in_b;
            mem_tag_q[wr_ptr_q] <= in_tag;
        end
    end

endmodule

// File: tb/tb_half_mult_issue_stage.sv
module tb_half_mult_issue_stage;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic                   CLK;
    logic                   RST;
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_a;
    logic [15:0]            in_b;
    logic [TAG_W-1:0]       in_tag;
    logic [15:0]            mult_float1;
    logic [15:0]            mult_float2;
    logic [15:0]            mult_product;
    logic                   out_valid;
    logic                   out_ready;
    logic [15:0]            out_product;
    logic [TAG_W-1:0]       out_tag;
    logic [4:0]             out_flags;
    logic [$clog2(DEPTH):0] occupancy;

    int n_cmp = 0;
    int n_err = 0;

    // Stand-in for float_mult_16bit: exact values for the documented cases,
    // otherwise an arbitrary deterministic mix of the operands.
    function automatic logic [15:0] mock_mult(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000: return 16'h4000;
            32'h0000_7C00: return 16'hFFFF;
            32'h7C01_3C00: return 16'hFDFF;
            32'h0000_3C00: return 16'h0000;
            32'h7800_7800: return 16'hFDFF;
            default:       return {a[15] ^ b[15], (a[14:0] + b[14:0]) ^ 15'h1234};
        endcase
    endfunction

    assign mult_product = mock_mult(mult_float1, mult_float2);

    half_mult_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .mult_float1  (mult_float1),
        .mult_float2  (mult_float2),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_tag      (out_tag),
        .out_flags    (out_flags),
        .occupancy    (occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: queue of buffered pairs plus the output slot.
    typedef struct packed {
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
    } item_t;

    item_t            pend[$];
    logic             m_ov;
    logic [15:0]      m_prod;
    logic [TAG_W-1:0] m_tag;
    logic [4:0]       m_flags;

    // Flags from the classification rules: class index 0..4 is the bit to set.
    function automatic logic [4:0] ref_flags(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] p);
        bit exa = (a[14:10] == 5'h1F);
        bit exb = (b[14:10] == 5'h1F);
        bit ai  = exa && (a[9:0] == 0);
        bit bi  = exb && (b[9:0] == 0);
        bit aq  = exa && a[9];
        bit bq  = exb && b[9];
        bit as_ = exa && !a[9] && (a[9:0] != 0);
        bit bs_ = exb && !b[9] && (b[9:0] != 0);
        int cls;
        if ((a == 0 && !bi) || (b == 0 && !ai))                 cls = 0;
        else if (aq || bq || (a == 0 && bi) || (b == 0 && ai))  cls = 1;
        else if (as_ || bs_)                                    cls = 2;
        else if (ai || bi)                                      cls = 3;
        else if (p == 16'hFDFF)                                 cls = 4;
        else                                                    cls = 5;
        if (cls == 5) return 5'b00000;
        return 5'(1 << cls);
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_ov    = 1'b0;
        m_prod  = 16'h0000;
        m_tag   = '0;
        m_flags = 5'b00000;
    endtask

    // One clock cycle: check pre-edge handshake state, advance model at the
    // edge, then check the registered outputs on the following negedge.
    task automatic step(output bit acc);
        bit    ld;
        item_t it;
        chk("in_ready", 32'(in_ready), 32'(pend.size() < DEPTH));
        chk("occupancy", 32'(occupancy), 32'(pend.size()));
        chk("mult_float1", 32'(mult_float1), pend.size() != 0 ? 32'(pend[0].a) : 32'h0);
        chk("mult_float2", 32'(mult_float2), pend.size() != 0 ? 32'(pend[0].b) : 32'h0);
        acc = in_valid && (pend.size() < DEPTH);
        ld  = (pend.size() != 0) && (!m_ov || out_ready);
        @(posedge CLK);
        if (ld) begin
            it      = pend.pop_front();
            m_prod  = mock_mult(it.a, it.b);
            m_tag   = it.tag;
            m_flags = ref_flags(it.a, it.b, m_prod);
            m_ov    = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (acc) pend.push_back('{a: in_a, b: in_b, tag: in_tag});
        @(negedge CLK);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_product", 32'(out_product), 32'(m_prod));
        chk("out_tag", 32'(out_tag), 32'(m_tag));
        chk("out_flags", 32'(out_flags), 32'(m_flags));
    endtask

    // Push one pair into an empty stage with out_ready high, then check
    // the documented result two cycles later.
    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t,
                          input logic [15:0] exp_p, input logic [4:0] exp_f, input string nm);
        bit acc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
        step(acc);
        in_valid  = 1'b0;
        chk({nm, "_valid_early"}, 32'(out_valid), 32'h0);
        step(acc);
        chk({nm, "_valid"}, 32'(out_valid), 32'h1);
        chk({nm, "_product"}, 32'(out_product), 32'(exp_p));
        chk({nm, "_tag"}, 32'(out_tag), 32'(t));
        chk({nm, "_flags"}, 32'(out_flags), 32'(exp_f));
        step(acc);
    endtask

    logic [15:0] specials [8] = '{16'h0000, 16'h7C00, 16'h7C01, 16'h7E00,
                                  16'h3C00, 16'h7800, 16'h8000, 16'hFC00};

    function automatic logic [15:0] rand_op();
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        bit acc;
        int n_acc;
        int idx;

        // Reset state
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_flags", 32'(out_flags), 32'h0);
        chk("rst_product", 32'(out_product), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge CLK);

        // Basic multiply and special operands
        single(16'h3C00, 16'h4000, 4'h5, 16'h4000, 5'b00000, "basic");
        single(16'h0000, 16'h7C00, 4'h1, 16'hFFFF, 5'b00010, "zero_x_inf");
        single(16'h7C01, 16'h3C00, 4'h2, 16'hFDFF, 5'b00100, "snan");
        single(16'h0000, 16'h3C00, 4'h3, 16'h0000, 5'b00001, "zero");
        single(16'h7800, 16'h7800, 4'h4, 16'hFDFF, 5'b10000, "overflow");

        // Backpressure: offer four pairs with the consumer stalled
        out_ready = 1'b0;
        n_acc = 0;
        idx   = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            in_a     = 16'h3C00 + 16'(idx);
            in_b     = 16'h4000 + 16'(idx);
            in_tag   = TAG_W'(8 + idx);
            step(acc);
            if (acc) begin
                n_acc++;
                idx++;
            end
        end
        chk("bp_accepted", 32'(n_acc), 32'd3);
        chk("bp_in_ready_full", 32'(in_ready), 32'h0);
        chk("bp_tag_held", 32'(out_tag), 32'h8);

        // Pop at full: the offered pair is still refused this cycle
        out_ready = 1'b1;
        chk("full_pop_in_ready", 32'(in_ready), 32'h0);
        chk("full_pop_occupancy", 32'(occupancy), 32'(DEPTH));
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            step(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_drained", 32'(occupancy), 32'h0);

        // Random back-to-back traffic against the model
        idx = 0;
        for (int c = 0; c < 60 && idx < 20; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rand_op();
            in_b      = rand_op();
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step(acc);
        chk("rand_count", 32'(idx), 32'd20);

        // Reset mid-operation discards everything in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h4000;
        in_b      = 16'h4200;
        in_tag    = 4'hA;
        for (int c = 0; c < 3; c++) step(acc);
        in_valid = 1'b0;
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_occupancy", 32'(occupancy), 32'h0);
        chk("midrst_flags", 32'(out_flags), 32'h0);
        chk("midrst_tag", 32'(out_tag), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        @(negedge CLK);
        single(16'h3C00, 16'h4000, 4'h7, 16'h4000, 5'b00000, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
